// File: rtl/fm_demodulator.sv
// rtl/fm_demodulator.sv - FM demodulator: zero-crossing period timer, reciprocal divider, message recovery.
module fm_demodulator #(
  parameter int AVG_LOG2 = 2,
  parameter int CNT_W    = 24,
  parameter int HYST     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  modulated,
  input  logic [31:0] ctr_ctrl,
  input  logic [4:0]  deviation,
  output logic [7:0]  message,
  output logic        message_valid,
  output logic [31:0] freq_est,
  output logic        timeout,
  output logic        overrun
);

  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0]      N_PER    = CW'(2 ** AVG_LOG2);
  localparam logic [CNT_W-1:0]   T_MAX    = '1;
  localparam logic signed [7:0]  HYST_NEG = 8'(-HYST);
  // Dividend bits above bit 32 of 2^(32+AVG_LOG2), preloaded into the remainder.
  localparam logic [CNT_W:0]     REM_INIT = (CNT_W + 1)'((1 << AVG_LOG2) >> 1);

  typedef enum logic {SYNC, MEASURE} state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CW-1:0]     count_q, count_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic [5:0]        iter_q, iter_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [32:0]       quo_q, quo_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [31:0]       qres_q, qres_d;
  logic [7:0]        message_q, message_d;
  logic [31:0]       freq_q, freq_d;
  logic              valid_q, valid_d;

  logic              crossing;
  logic              start;
  logic [CW-1:0]     count_inc;
  logic              in_bit;
  logic [CNT_W:0]    r_shift;
  logic [CNT_W:0]    r_sub;
  logic              ge;
  logic signed [32:0] diff;
  logic signed [32:0] shifted;

  // Crossing detector with hysteresis
  always_comb begin
    crossing = armed_q && !modulated[7];
    armed_d  = armed_q;
    if (crossing) begin
      armed_d = 1'b0;
    end else if ($signed(modulated) <= HYST_NEG) begin
      armed_d = 1'b1;
    end
  end

  // Measurement FSM
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    start     = 1'b0;
    count_inc = count_q + CW'(1);
    case (state_q)
      SYNC: begin
        if (crossing) begin
          timer_d = CNT_W'(1);
          count_d = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (crossing) begin
          if (count_inc == N_PER) begin
            start     = !busy_q;
            overrun_d = busy_q;
            timer_d   = CNT_W'(1);
            count_d   = '0;
          end else begin
            count_d = count_inc;
            timer_d = (timer_q == T_MAX) ? T_MAX : timer_q + CNT_W'(1);
          end
        end else if (timer_q == T_MAX) begin
          timeout_d = 1'b1;
          state_d   = SYNC;
          timer_d   = '0;
          count_d   = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Restoring divider: 33 quotient bits, then a finishing cycle that saturates
  always_comb begin
    busy_d  = busy_q;
    iter_d  = iter_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    qres_d  = qres_q;
    in_bit  = (AVG_LOG2 == 0) && (iter_q == 6'd0);
    r_shift = {rem_q, in_bit};
    r_sub   = r_shift - {1'b0, div_q};
    ge      = r_shift >= {1'b0, div_q};
    if (start) begin
      busy_d = 1'b1;
      iter_d = '0;
      div_d  = timer_q;
      rem_d  = REM_INIT[CNT_W-1:0];
      ovf_d  = REM_INIT >= {1'b0, timer_q};
      quo_d  = '0;
    end else if (busy_q) begin
      if (iter_q == 6'd33) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        qres_d = (ovf_q || quo_q[32]) ? 32'hFFFF_FFFF : quo_q[31:0];
      end else begin
        rem_d  = CNT_W'(ge ? r_sub : r_shift);
        quo_d  = {quo_q[31:0], ge};
        iter_d = iter_q + 6'd1;
      end
    end
  end

  // Output stage: remove centre word, undo deviation shift, saturate
  always_comb begin
    message_d = message_q;
    freq_d    = freq_q;
    valid_d   = 1'b0;
    diff      = $signed({1'b0, qres_q}) - $signed({1'b0, ctr_ctrl});
    shifted   = diff >>> deviation;
    if (done_q) begin
      valid_d = 1'b1;
      freq_d  = qres_q;
      if (shifted > 33'sd127) begin
        message_d = 8'h7F;
      end else if (shifted < -33'sd128) begin
        message_d = 8'h80;
      end else begin
        message_d = shifted[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      armed_q   <= 1'b0;
      timer_q   <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      iter_q    <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      qres_q    <= '0;
      message_q <= '0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      iter_q    <= iter_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      qres_q    <= qres_d;
      message_q <= message_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
    end
  end

  assign message       = message_q;
  assign message_valid = valid_q;
  assign freq_est      = freq_q;
  assign timeout       = timeout_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fm_demodulator.sv
// tb/tb_fm_demodulator.sv - scoreboard bench for fm_demodulator driven by directed square-wave phases.
module tb_fm_demodulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  modulated = 8'h00;
  logic [31:0] ctr_ctrl = 32'h0;
  logic [4:0]  deviation = 5'd0;
  logic [7:0]  message;
  logic        message_valid;
  logic [31:0] freq_est;
  logic        timeout;
  logic        overrun;

  always #5 clk = ~clk;

  fm_demodulator #(.AVG_LOG2(2), .CNT_W(12), .HYST(16)) dut (
    .clk(clk), .rst(rst), .modulated(modulated), .ctr_ctrl(ctr_ctrl),
    .deviation(deviation), .message(message), .message_valid(message_valid),
    .freq_est(freq_est), .timeout(timeout), .overrun(overrun)
  );

  typedef struct {
    logic [31:0] q;
    logic [7:0]  m;
    int          e;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          edge_cnt = 0;
  int          valid_cnt = 0;
  int          ovr_cnt = 0;
  int          to_cnt = 0;
  int          to_edge = 0;
  int          cross_k = 0;
  int          first_edge = 0;
  int          last_edge = 0;
  bit          sticky = 1'b0;
  logic [31:0] sticky_q = 32'h0;
  logic [7:0]  sticky_m = 8'h0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_q(input longint t);
    longint q;
    q = (64'sd1 <<< 34) / t;
    return (q > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(q);
  endfunction

  function automatic logic [7:0] exp_msg(input logic [31:0] q, input logic [31:0] c, input int dev);
    longint d;
    d = longint'({32'h0, q}) - longint'({32'h0, c});
    d = d >>> dev;
    if (d > 127) return 8'h7F;
    if (d < -128) return 8'h80;
    return 8'(d);
  endfunction

  always @(negedge clk) begin
    if (message_valid) begin
      valid_cnt++;
      if (sticky) begin
        chk("ovr_freq", freq_est, sticky_q);
        chk("ovr_msg", message, sticky_m);
      end else if (sb.size() == 0) begin
        chk("unexpected_valid", message_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("freq_est", freq_est, mon_e.q);
        chk("message", message, mon_e.m);
        chk("latency_edge", edge_cnt, mon_e.e);
      end
    end
    if (overrun) ovr_cnt++;
    if (timeout) begin
      to_cnt++;
      to_edge = edge_cnt;
    end
  end

  task automatic step(input int v);
    @(negedge clk);
    modulated = v[7:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    modulated = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    cross_k = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_message"}, message, 0);
    chk({pfx, "_freq_est"}, freq_est, 0);
    chk({pfx, "_valid"}, message_valid, 0);
    chk({pfx, "_timeout"}, timeout, 0);
    chk({pfx, "_overrun"}, overrun, 0);
  endtask

  task automatic square(input int p, input int n, input bit push);
    int ec;
    logic [31:0] q;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < p / 2; j++) step(-100);
      for (int j = 0; j < p / 2; j++) begin
        step(100);
        if (j == 0) begin
          ec = edge_cnt + 1;
          if (cross_k == 0) first_edge = ec;
          last_edge = ec;
          if (push && cross_k > 0 && (cross_k % 4) == 0) begin
            q = exp_q(longint'(4 * p));
            sb.push_back('{q: q, m: exp_msg(q, ctr_ctrl, int'(deviation)), e: ec + 35});
          end
          cross_k++;
        end
      end
    end
  endtask

  initial begin
    int v0;
    int o0;
    int r;

    do_reset();
    chk_zero("reset");

    // Centre frequency: period 16 -> Q = 0x10000000, message 0, results 64 clocks apart
    ctr_ctrl = 32'h1000_0000;
    deviation = 5'd20;
    square(16, 9, 1);
    idle(40);
    chk("p16_drained", sb.size(), 0);
    chk("p16_freq", freq_est, 32'h1000_0000);

    do_reset();
    square(20, 5, 1);
    idle(40);
    chk("p20_drained", sb.size(), 0);
    chk("p20_msg", message, 8'hCC);

    do_reset();
    deviation = 5'd0;
    square(20, 5, 1);
    idle(40);
    chk("sat_neg_msg", message, 8'h80);

    do_reset();
    ctr_ctrl = 32'h0;
    square(8, 5, 1);
    idle(40);
    chk("sat_pos_msg", message, 8'h7F);
    chk("sat_drained", sb.size(), 0);

    // Timeout after sync, then recovery
    do_reset();
    ctr_ctrl = 32'h1000_0000;
    deviation = 5'd20;
    v0 = valid_cnt;
    square(16, 2, 0);
    for (int i = 0; i < 5000 && to_cnt == 0; i++) step(0);
    chk("timeout_seen", to_cnt, 1);
    chk("timeout_edge", to_edge, first_edge + 4095);
    chk("timeout_no_valid", valid_cnt - v0, 0);
    cross_k = 0;
    square(20, 5, 1);
    idle(40);
    chk("resume_drained", sb.size(), 0);
    chk("resume_timeouts", to_cnt, 1);

    // Ripple below hysteresis must not create crossings
    do_reset();
    square(16, 5, 1);
    v0 = valid_cnt;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(20, 0));
      step(r - 10);
    end
    chk("ripple_one_valid", valid_cnt - v0, 1);
    chk("ripple_freq", freq_est, 32'h1000_0000);
    chk("ripple_drained", sb.size(), 0);

    // Period 2: measurements every 8 clocks overrun a 34-cycle busy divider
    do_reset();
    deviation = 5'd24;
    sticky_q = 32'h8000_0000;
    sticky_m = exp_msg(32'h8000_0000, 32'h1000_0000, 24);
    sticky = 1'b1;
    v0 = valid_cnt;
    o0 = ovr_cnt;
    square(2, 60, 0);
    idle(40);
    sticky = 1'b0;
    chk("ovr_valid_count", valid_cnt - v0, 3);
    chk("ovr_pulse_count", ovr_cnt - o0, 11);

    // Reset 20 clocks into a divide
    do_reset();
    deviation = 5'd20;
    square(16, 5, 0);
    while (edge_cnt + 1 < last_edge + 20) step(0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("middiv");
    rst = 1'b0;
    cross_k = 0;
    v0 = valid_cnt;
    idle(45);
    chk("middiv_no_valid", valid_cnt - v0, 0);
    square(16, 5, 1);
    idle(40);
    chk("middiv_recover", valid_cnt - v0, 1);
    chk("middiv_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fm_demodulator.md
Name: fm_demodulator

Overview:
- Recovers the signed 8-bit message from a signed 8-bit FM waveform, the receive-side counterpart of the FM modulator.
- Detects rising zero crossings with hysteresis and times 2^AVG_LOG2 consecutive carrier periods in clock cycles.
- Converts that time to an NCO-style 32-bit frequency word with a sequential divider.
- Removes the centre word and undoes the deviation shift, using the same ctr_ctrl/deviation convention as the transmit path.

Parameters:
- AVG_LOG2, 2, log2 of carrier periods averaged per estimate (0..4).
- CNT_W, 24, width of the period timer in bits.
- HYST, 16, magnitude threshold that arms the crossing detector (1..127).

Ports:
- clk  input  1  system clock; one input sample per cycle
- rst  input  1  synchronous, active-high reset
- modulated  input  8  signed FM input sample
- ctr_ctrl  input  32  centre frequency control word; same scaling as the NCO
- deviation  input  5  left-shift amount applied to the message at the transmitter
- message  output  8  signed recovered message; held between updates
- message_valid  output  1  one-cycle strobe when message and freq_est update
- freq_est  output  32  estimated frequency word, floor(2^(32+AVG_LOG2)/T)
- timeout  output  1  one-cycle strobe when the timer saturates without completing a measurement
- overrun  output  1  one-cycle strobe when a measurement completes while the divider is busy; that measurement is dropped

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: message=0, freq_est=0, message_valid=0, timeout=0, overrun=0; detector disarmed; timer=0; period count=0; FSM in SYNC; divider idle.
- Crossing detector:
  - Arm when the signed sample is <= -HYST.
  - Crossing event on the first cycle an armed detector sees sample >= 0; the detector then disarms.
  - Samples in (-HYST, 0) neither arm nor fire.
- Measurement FSM:
  - SYNC: wait for a crossing. On a crossing: timer=1, period count=0, go to MEASURE.
  - MEASURE: timer increments every cycle. Each crossing increments the period count.
  - When the count reaches 2^AVG_LOG2, the timer value at that crossing's cycle is T (clocks from the first crossing to the final one). Then:
    - if the divider is idle, T is handed to the divider;
    - if the divider is busy, overrun pulses and T is discarded.
  - In both cases the timer restarts at 1 and the count at 0. The final crossing is the start of the next measurement (continuous, no gap).
  - Timer reaching 2^CNT_W-1: timeout pulses for one cycle, the measurement is discarded, return to SYNC.
- Divider:
  - Restoring, one quotient bit per cycle, 33 iterations.
  - Computes Q = floor(2^(32+AVG_LOG2)/T), saturated to 0xFFFFFFFF if it exceeds 32 bits.
  - T=1 cannot occur, since the minimum T is 2 with AVG_LOG2=0.
  - Busy from the handoff cycle through the last iteration.
- Output stage (one registered cycle after divider completion):
  - d = Q - ctr_ctrl as a 33-bit signed value.
  - m = d >>> deviation, arithmetic shift, which floors toward -inf.
  - Saturate m to [-128, 127].
  - message <= m, freq_est <= Q, message_valid pulses 1 cycle.
  - ctr_ctrl and deviation are sampled in this cycle.
- Latency: message_valid asserts exactly 35 clocks after the closing crossing is sampled.
- Simultaneous events:
  - Timeout and crossing in the same cycle: the crossing wins; timeout does not fire.
  - Overrun and divider completion in the same cycle: the divider is still busy on that cycle, so overrun fires.
- Reset mid-measurement or mid-divide: everything returns to reset values next cycle; no message_valid for the aborted work.

Test Plan:
- Square wave +100/-100, period 16 clk, AVG_LOG2=2, ctr_ctrl=0x10000000, deviation=20 -> freq_est=0x10000000, message=0, message_valid every 64 clk after the first result.
- Same stimulus with period 20 -> T=80, freq_est=0x0CCCCCCC, message=-52 (floor of -51.2).
- Period 20, ctr_ctrl=0x10000000, deviation=0 -> message saturates to -128. Period 8, ctr_ctrl=0, deviation=0 -> message=127.
- Constant input 0 after sync -> timeout strobe at timer=2^24-1, no message_valid, FSM back in SYNC. A resumed square wave then yields valid results.
- Ripple within ±10 around 0 (below HYST) between valid cycles -> no extra crossings, freq_est unchanged. AVG_LOG2=0 with period 2 -> overrun pulses while the divider is busy, and completed results remain correct.
- Assert rst during the divide (20 clk after the handoff) -> no message_valid, all outputs 0. The next measurement completes normally.
